peripheral_uart_wb_master: RTL and testbench
============================================

// Module: peripheral_uart_wb_master
// PURPOSE
//  Wishbone initiator that owns the UART's 8-bit register slave (16550 map).
//  After reset it programs the divisor, LCR, FCR and IER, then polls LSR.
//  It moves bytes between byte-stream ports and THR/RBR, so a core streams UART data without software.
//  It sits between the stream client and the UART Wishbone slave port.
// PARAMETERS
//  DIVISOR      16'd27   baud divisor written to DLL (low byte) and DLM (high byte)
//  LCR_VALUE    8'h03    line control value, bit7 must be 0 (default 8N1)
//  ACK_TIMEOUT  16       cycles to wait for wb_ack_i before aborting an access
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rst_i     in   1   asynchronous reset, active-high
//  wb_adr_o     out  3   register address
//  wb_dat_o     out  8   write data
//  wb_dat_i     in   8   read data
//  wb_we_o      out  1   1=write, 0=read
//  wb_stb_o     out  1   strobe
//  wb_cyc_o     out  1   cycle
//  wb_sel_o     out  4   byte select, constant 4'b0001
//  wb_ack_i     in   1   slave acknowledge
//  tx_data_i    in   8   byte to transmit
//  tx_valid_i   in   1   tx byte offered
//  tx_ready_o   out  1   tx holding register empty; byte accepted when valid&ready
//  rx_data_o    out  8   received byte
//  rx_valid_o   out  1   rx byte held; stays high until rx_ready_i
//  rx_ready_i   in   1   consumer accepts rx byte
//  init_done_o  out  1   1 once the init sequence has completed
//  err_o        out  1   1-cycle pulse on an ack timeout
// BEHAVIOUR
//  Reset values
//   - All outputs are 0, except wb_sel_o=4'b0001.
//   - Holding registers empty; FSM enters INIT step 0.
//   - Reset asserted mid-access drops cyc/stb immediately.
//  Bus access
//   - Cycle N: cyc=stb=1 with adr/dat/we stable. Hold until wb_ack_i is sampled high.
//   - Next cycle: cyc=stb=0. This gives at least one idle cycle between accesses.
//   - Read data is captured in the ack cycle.
//  Ack timeout
//   - If ACK_TIMEOUT cycles pass with no ack: drop cyc/stb and pulse err_o.
//   - During INIT: restart INIT at step 0.
//   - Otherwise: return to POLL, discarding nothing (tx byte retained).
//  INIT sequence (writes, in order)
//   - LCR(3)=LCR_VALUE|8'h80
//   - DLL(0)=DIVISOR[7:0]
//   - DLM(1)=DIVISOR[15:8]
//   - LCR(3)=LCR_VALUE
//   - FCR(2)=8'h07
//   - IER(1)=8'h00
//   - Then init_done_o=1 (sticky until reset) and go to POLL.
//  FSM states
//   INIT  -> POLL after last init write acked.
//   POLL  -> read LSR (adr 5). On ack, latch lsr and go to DECIDE.
//   DECIDE (evaluated in order):
//     - lsr[0]=1 and rx holding empty -> RDRBR.
//     - else lsr[5]=1 and tx holding full -> WRTHR.
//     - else -> POLL.
//   RDRBR -> read adr 0; on ack load rx_data_o and set rx_valid_o -> POLL.
//   WRTHR -> write adr 0 with the tx byte; on ack empty tx holding -> POLL.
//  RX priority
//   - RX is serviced before TX, to avoid overrun.
//   - If rx holding is full, RBR is not read.
//  Stream handshakes
//   - tx_ready_o = ~tx_full.
//   - tx_ready_o is independent of FSM state, but is 0 before init_done_o.
//   - Simultaneous rx_ready_i and a new RBR ack cannot occur: RDRBR only starts when rx holding is empty.
//   - rx_valid_o drops the cycle after rx_valid_o&rx_ready_i.
// TESTING
//  1. Reset release, slave acks in 1 cycle -> six writes (3:83,0:1B,1:00,3:03,2:07,1:00); init_done_o=1.
//  2. tx_data_i=8'hA5 with LSR=8'h60 -> exactly one write adr0 dat A5; tx_ready_o returns 1.
//  3. LSR=8'h61, RBR=8'h3C, rx_ready_i=0 -> rx_data_o=3C, rx_valid_o=1; RBR not re-read until accepted.
//  4. LSR=8'h61 with tx byte 8'h55 pending -> RBR read precedes THR write of 55.
//  5. Slave never acks LSR read -> stb drops after 16 cycles, err_o pulses once, polling resumes.
//  6. Reset asserted while stb=1 in WRTHR -> all outputs 0 next edge; INIT restarts from LCR=83.

Source files
------------

// File: rtl/peripheral_uart_wb_master_if.sv
// Wishbone master bus toward the UART register slave plus the byte-stream client ports.
interface peripheral_uart_wb_master_if;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       init_done_o;
  logic       err_o;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
    output tx_ready_o, rx_data_o, rx_valid_o, init_done_o, err_o,
    input  wb_dat_i, wb_ack_i, tx_data_i, tx_valid_i, rx_ready_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
    input  tx_ready_o, rx_data_o, rx_valid_o, init_done_o, err_o,
    output wb_dat_i, wb_ack_i, tx_data_i, tx_valid_i, rx_ready_i
  );
endinterface

// File: rtl/peripheral_uart_wb_master.sv
// Wishbone initiator that programs a 16550-style UART and then shuttles bytes
// between the stream ports and THR/RBR by polling LSR.
module peripheral_uart_wb_master #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VALUE   = 8'h03,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  peripheral_uart_wb_master_if.master bus
);

  localparam int unsigned TMO_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0] INIT_LAST  = 3'd5;
  localparam logic [2:0] ADR_DATA   = 3'd0;
  localparam logic [2:0] ADR_LSR    = 3'd5;

  typedef enum logic [2:0] {
    S_INIT,
    S_POLL,
    S_DECIDE,
    S_RDRBR,
    S_WRTHR
  } state_t;

  state_t           state;
  logic [2:0]       step;
  logic [TMO_W-1:0] tmo;
  logic             cyc;
  logic [2:0]       adr;
  logic [7:0]       dat;
  logic             we;
  logic             lsr_dr;
  logic             lsr_thre;
  logic             tx_full;
  logic [7:0]       tx_byte;
  logic             tx_ready;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             init_done;
  logic             err;

  logic [2:0]       req_adr;
  logic [7:0]       req_dat;
  logic             req_we;

  // Address/data/direction of the access the current state wants to issue.
  always_comb begin
    req_adr = 3'd0;
    req_dat = 8'h00;
    req_we  = 1'b0;
    case (state)
      S_INIT: begin
        req_we = 1'b1;
        case (step)
          3'd0:    begin req_adr = 3'd3; req_dat = LCR_VALUE | 8'h80; end
          3'd1:    begin req_adr = 3'd0; req_dat = DIVISOR[7:0];      end
          3'd2:    begin req_adr = 3'd1; req_dat = DIVISOR[15:8];     end
          3'd3:    begin req_adr = 3'd3; req_dat = LCR_VALUE;         end
          3'd4:    begin req_adr = 3'd2; req_dat = 8'h07;             end
          default: begin req_adr = 3'd1; req_dat = 8'h00;             end
        endcase
      end
      S_POLL:  req_adr = ADR_LSR;
      S_RDRBR: req_adr = ADR_DATA;
      S_WRTHR: begin
        req_adr = ADR_DATA;
        req_dat = tx_byte;
        req_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Main controller: bus access sequencing, stream holding registers, init tracking.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_INIT;
      step      <= 3'd0;
      tmo       <= '0;
      cyc       <= 1'b0;
      adr       <= 3'd0;
      dat       <= 8'h00;
      we        <= 1'b0;
      lsr_dr    <= 1'b0;
      lsr_thre  <= 1'b0;
      tx_full   <= 1'b0;
      tx_byte   <= 8'h00;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;

      if (rx_valid && bus.rx_ready_i) rx_valid <= 1'b0;

      // tx_ready is only ever high when the holding register is empty
      if (tx_ready && bus.tx_valid_i) begin
        tx_full  <= 1'b1;
        tx_byte  <= bus.tx_data_i;
        tx_ready <= 1'b0;
      end

      if (state == S_DECIDE) begin
        // RX first so the UART receive buffer cannot overrun behind a TX byte
        if (lsr_dr && !rx_valid)      state <= S_RDRBR;
        else if (lsr_thre && tx_full) state <= S_WRTHR;
        else                          state <= S_POLL;
      end else if (!cyc) begin
        adr <= req_adr;
        dat <= req_dat;
        we  <= req_we;
        cyc <= 1'b1;
        tmo <= '0;
      end else if (bus.wb_ack_i) begin
        cyc <= 1'b0;
        case (state)
          S_INIT: begin
            if (step == INIT_LAST) begin
              step      <= 3'd0;
              init_done <= 1'b1;
              tx_ready  <= ~tx_full;
              state     <= S_POLL;
            end else begin
              step <= step + 3'd1;
            end
          end
          S_POLL: begin
            lsr_dr   <= bus.wb_dat_i[0];
            lsr_thre <= bus.wb_dat_i[5];
            state    <= S_DECIDE;
          end
          S_RDRBR: begin
            rx_data  <= bus.wb_dat_i;
            rx_valid <= 1'b1;
            state    <= S_POLL;
          end
          S_WRTHR: begin
            tx_full  <= 1'b0;
            tx_ready <= 1'b1;
            state    <= S_POLL;
          end
          default: state <= S_POLL;
        endcase
      end else if (tmo == TMO_LAST) begin
        // Abandon the access; a pending tx byte stays held for the next attempt
        cyc <= 1'b0;
        err <= 1'b1;
        if (state == S_INIT) step  <= 3'd0;
        else                 state <= S_POLL;
      end else begin
        tmo <= tmo + TMO_W'(1);
      end
    end
  end

  assign bus.wb_adr_o    = adr;
  assign bus.wb_dat_o    = dat;
  assign bus.wb_we_o     = we;
  assign bus.wb_cyc_o    = cyc;
  assign bus.wb_stb_o    = cyc;
  assign bus.wb_sel_o    = 4'b0001;
  assign bus.tx_ready_o  = tx_ready;
  assign bus.rx_data_o   = rx_data;
  assign bus.rx_valid_o  = rx_valid;
  assign bus.init_done_o = init_done;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_peripheral_uart_wb_master.sv
// Bench: behavioural UART register slave plus stream scoreboards around the Wishbone master.
module tb_peripheral_uart_wb_master;

  localparam logic [15:0] DIV = 16'd27;
  localparam logic [7:0]  LCR = 8'h03;
  localparam int unsigned TMO = 16;

  typedef struct {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  acc_t       log_q[$];
  logic [7:0] uart_rx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  int lat = 0;
  bit rand_lat = 0;
  bit thr_rand = 0;
  bit thr_free = 1;
  bit lsr_hold = 0;
  bit drop_once = 0;
  int wait_cnt = 0;
  int stb_run = 0;
  int last_run = 0;
  int err_cnt = 0;
  bit rx_rand = 0;
  bit rx_force = 0;

  logic [2:0] e_adr [6];
  logic [7:0] e_dat [6];

  always #5 clk = ~clk;

  peripheral_uart_wb_master_if bus ();

  peripheral_uart_wb_master #(
    .DIVISOR    (DIV),
    .LCR_VALUE  (LCR),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int count_acc(input int from, input logic w, input logic [2:0] a);
    int n = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].we == w && log_q[i].adr == a) n++;
    return n;
  endfunction

  // Register-level effect of one acknowledged access on the simulated UART.
  task automatic respond();
    acc_t       a;
    logic       fr;
    logic [7:0] d;
    a.we  = bus.wb_we_o;
    a.adr = bus.wb_adr_o;
    d     = 8'h00;
    if (bus.wb_we_o) begin
      d = bus.wb_dat_o;
      if (bus.wb_adr_o == 3'd0 && bus.init_done_o) begin
        check("thr_pending", 32'(exp_tx_q.size() > 0), 32'd1);
        if (exp_tx_q.size() > 0) check("thr_data", 32'(d), 32'(exp_tx_q.pop_front()));
      end
    end else begin
      if (bus.wb_adr_o == 3'd5) begin
        fr = thr_rand ? ($urandom_range(0, 3) != 0) : thr_free;
        d  = lsr_hold ? 8'h00 : {1'b0, fr, fr, 4'b0000, uart_rx_q.size() != 0};
      end else if (bus.wb_adr_o == 3'd0) begin
        check("rbr_only_when_empty", 32'(bus.rx_valid_o), 32'd0);
        check("rbr_has_data", 32'(uart_rx_q.size() > 0), 32'd1);
        if (uart_rx_q.size() > 0) d = uart_rx_q.pop_front();
      end
      bus.wb_dat_i = d;
    end
    a.dat = d;
    log_q.push_back(a);
  endtask

  // UART slave: acks after `lat` wait cycles, can withhold one LSR ack.
  always @(negedge clk) begin
    if (rst) begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = 8'h00;
      wait_cnt = 0;
      stb_run  = 0;
    end else if (bus.wb_ack_i) begin
      check("idle_after_ack", 32'(bus.wb_cyc_o), 32'd0);
      bus.wb_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
      stb_run++;
      if (wait_cnt >= lat && !(drop_once && !bus.wb_we_o && bus.wb_adr_o == 3'd5)) begin
        respond();
        bus.wb_ack_i = 1'b1;
        stb_run  = 0;
        wait_cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end else begin
      if (stb_run > 0) begin
        last_run  = stb_run;
        drop_once = 0;
      end
      stb_run  = 0;
      wait_cnt = 0;
    end
    if (bus.err_o) err_cnt++;
  end

  // Stream consumer with scoreboard against bytes the UART received.
  always @(negedge clk) begin
    if (rst) begin
      bus.rx_ready_i = 1'b0;
    end else begin
      bus.rx_ready_i = rx_rand ? 1'($urandom_range(0, 1)) : rx_force;
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        check("rx_pending", 32'(exp_rx_q.size() > 0), 32'd1);
        if (exp_rx_q.size() > 0) check("rx_data", 32'(bus.rx_data_o), 32'(exp_rx_q.pop_front()));
      end
    end
  end

  task automatic send_tx(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus.tx_data_i  = b;
    bus.tx_valid_i = 1'b1;
    while (!bus.tx_ready_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("tx_accept_in_time", 32'(t < 3000), 32'd1);
    if (bus.tx_ready_o) exp_tx_q.push_back(b);
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic inject_rx(input logic [7:0] b);
    uart_rx_q.push_back(b);
    exp_rx_q.push_back(b);
  endtask

  task automatic wait_init();
    int t = 0;
    while (!bus.init_done_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("init_done", 32'(bus.init_done_o), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"},   32'(bus.wb_cyc_o),    32'd0);
    check({tag, "_stb"},   32'(bus.wb_stb_o),    32'd0);
    check({tag, "_we"},    32'(bus.wb_we_o),     32'd0);
    check({tag, "_adr"},   32'(bus.wb_adr_o),    32'd0);
    check({tag, "_dat"},   32'(bus.wb_dat_o),    32'd0);
    check({tag, "_sel"},   32'(bus.wb_sel_o),    32'd1);
    check({tag, "_txrdy"}, 32'(bus.tx_ready_o),  32'd0);
    check({tag, "_rxv"},   32'(bus.rx_valid_o),  32'd0);
    check({tag, "_rxd"},   32'(bus.rx_data_o),   32'd0);
    check({tag, "_init"},  32'(bus.init_done_o), 32'd0);
    check({tag, "_err"},   32'(bus.err_o),       32'd0);
  endtask

  initial begin
    int mark;
    int t;
    int idx_r;
    int idx_w;
    e_adr = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    e_dat = '{LCR | 8'h80, DIV[7:0], DIV[15:8], LCR, 8'h07, 8'h00};
    bus.tx_data_i  = 8'h00;
    bus.tx_valid_i = 1'b0;

    // Reset state and init sequence
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("txrdy_before_init", 32'(bus.tx_ready_o), 32'd0);
    wait_init();
    check("txrdy_after_init", 32'(bus.tx_ready_o), 32'd1);
    check("init_count", 32'(log_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < log_q.size()) begin
        check("init_we",  32'(log_q[i].we),  32'd1);
        check("init_adr", 32'(log_q[i].adr), 32'(e_adr[i]));
        check("init_dat", 32'(log_q[i].dat), 32'(e_dat[i]));
      end
    end

    // Single TX byte
    mark = log_q.size();
    send_tx(8'hA5);
    t = 0;
    while (!bus.tx_ready_o && t < 300) begin @(negedge clk); t++; end
    check("tx_ready_back", 32'(bus.tx_ready_o), 32'd1);
    check("thr_write_count", 32'(count_acc(mark, 1'b1, 3'd0)), 32'd1);
    check("tx_model_empty", 32'(exp_tx_q.size()), 32'd0);

    // RX byte held until consumed; RBR not re-read meanwhile
    rx_force = 1'b0;
    inject_rx(8'h3C);
    t = 0;
    while (!bus.rx_valid_o && t < 300) begin @(negedge clk); t++; end
    check("rx_valid_set", 32'(bus.rx_valid_o), 32'd1);
    check("rx_data_held", 32'(bus.rx_data_o), 32'h3C);
    mark = log_q.size();
    inject_rx(8'h77);
    repeat (60) @(negedge clk);
    check("rbr_not_reread", 32'(count_acc(mark, 1'b0, 3'd0)), 32'd0);
    check("rx_still_valid", 32'(bus.rx_valid_o), 32'd1);
    check("rx_still_3c", 32'(bus.rx_data_o), 32'h3C);
    rx_force = 1'b1;
    t = 0;
    while ((exp_rx_q.size() != 0 || bus.rx_valid_o) && t < 500) begin @(negedge clk); t++; end
    check("rx_drained", 32'(exp_rx_q.size()), 32'd0);
    rx_force = 1'b0;

    // RX serviced before TX when both are ready at the same LSR read
    lsr_hold = 1;
    repeat (6) @(negedge clk);
    send_tx(8'h55);
    inject_rx(8'h5A);
    repeat (10) @(negedge clk);
    mark = log_q.size();
    lsr_hold = 0;
    t = 0;
    while (exp_tx_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    idx_r = -1;
    idx_w = -1;
    for (int i = mark; i < log_q.size(); i++) begin
      if (!log_q[i].we && log_q[i].adr == 3'd0 && idx_r < 0) idx_r = i;
      if (log_q[i].we && log_q[i].adr == 3'd0 && idx_w < 0) idx_w = i;
    end
    check("thr_written", 32'(idx_w >= 0), 32'd1);
    check("rbr_before_thr", 32'(idx_r >= 0 && idx_r < idx_w), 32'd1);
    if (idx_w >= 0) check("thr_55", 32'(log_q[idx_w].dat), 32'h55);
    rx_force = 1'b1;
    t = 0;
    while (exp_rx_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    check("rx_5a_drained", 32'(exp_rx_q.size()), 32'd0);
    rx_force = 1'b0;

    // Ack timeout on an LSR read
    last_run  = 0;
    drop_once = 1;
    t = 0;
    while (last_run == 0 && t < 300) begin @(negedge clk); t++; end
    mark = log_q.size();
    repeat (30) @(negedge clk);
    check("timeout_stb_cycles", 32'(last_run), 32'(TMO));
    check("timeout_err_pulses", 32'(err_cnt), 32'd1);
    check("poll_resumed", 32'(count_acc(mark, 1'b0, 3'd5) > 0), 32'd1);

    // Randomised traffic in both directions
    rand_lat = 1;
    thr_rand = 1;
    rx_rand  = 1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_tx(8'($urandom));
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          inject_rx(8'($urandom));
        end
      end
    join
    t = 0;
    while ((exp_tx_q.size() != 0 || exp_rx_q.size() != 0 || uart_rx_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("rand_tx_drained", 32'(exp_tx_q.size()), 32'd0);
    check("rand_rx_drained", 32'(exp_rx_q.size()), 32'd0);
    check("no_extra_err", 32'(err_cnt), 32'd1);
    rand_lat = 0;
    thr_rand = 0;
    rx_rand  = 0;
    rx_force = 0;
    repeat (5) @(negedge clk);
    lat = 8;

    // Reset in the middle of a THR write
    send_tx(8'hC3);
    t = 0;
    while (!(bus.init_done_o && bus.wb_cyc_o && bus.wb_we_o && bus.wb_adr_o == 3'd0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("wrthr_reached", 32'(t < 500), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("midreset");
    exp_tx_q.delete();
    exp_rx_q.delete();
    uart_rx_q.delete();
    log_q.delete();
    lat = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init();
    check("reinit_count", 32'(log_q.size() > 0), 32'd1);
    if (log_q.size() > 0) begin
      check("reinit_first_we",  32'(log_q[0].we),  32'd1);
      check("reinit_first_adr", 32'(log_q[0].adr), 32'd3);
      check("reinit_first_dat", 32'(log_q[0].dat), 32'h83);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
